// File: rtl/intel_hex_pkg.sv
// Shared types and constants for the Intel HEX record parser.
package intel_hex_pkg;

  typedef enum logic [3:0] {
    WAIT_COLON,
    COUNT,
    ADDR_HI,
    ADDR_LO,
    TYPE,
    DATA,
    CHECKSUM,
    DONE,
    ERROR
  } state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_BAD_CHAR  = 3'd1;
  localparam logic [2:0] ERR_CHECKSUM  = 3'd2;
  localparam logic [2:0] ERR_BAD_TYPE  = 3'd3;
  localparam logic [2:0] ERR_EOF_COUNT = 3'd4;

  localparam logic [7:0] REC_DATA   = 8'h00;
  localparam logic [7:0] REC_EOF    = 8'h01;
  localparam logic [7:0] COLON_CHAR = 8'h3A;

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> 4-bit value.
module hex_nibble_decode (
  input  logic [7:0] ch,
  output logic [3:0] value,
  output logic       valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    value = 4'h0;
    valid = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      value = 4'(ch - 8'h30);
      valid = 1'b1;
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      value = 4'(ch - 8'h37);
      valid = 1'b1;
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      value = 4'(ch - 8'h57);
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/intel_hex_parser.sv
// Streaming Intel HEX parser: one ASCII character per i_en strobe, emits decoded data bytes.
// Define IHEX_CHECKSUM_EN to turn a record checksum mismatch into error code 2.
module intel_hex_parser
  import intel_hex_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [7:0]        i_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_data,
  output logic              o_data_valid,
  output logic              o_idle,
  output logic [2:0]        o_error_code,
  output logic              o_parse_complete
);

`ifdef IHEX_CHECKSUM_EN
  localparam bit CSUM_CHECK = 1'b1;
`else
  localparam bit CSUM_CHECK = 1'b0;
`endif

  state_e      state;
  logic        have_hi;
  logic [3:0]  hi_nib;
  logic [7:0]  count;
  logic [7:0]  rec_type;
  logic [7:0]  idx;
  logic [7:0]  csum;
  logic [15:0] rec_addr;

  logic [3:0]  nib;
  logic        nib_ok;
  logic [7:0]  byte_val;
  logic [7:0]  csum_next;
  logic        is_colon;
  logic        csum_bad;

  hex_nibble_decode u_dec (
    .ch    (i_data),
    .value (nib),
    .valid (nib_ok)
  );

  assign byte_val  = {hi_nib, nib};
  assign csum_next = csum + byte_val;
  assign is_colon  = (i_data == COLON_CHAR);
  // The checksum byte itself is part of the sum, so a good record totals zero.
  assign csum_bad  = CSUM_CHECK && (csum_next != 8'h00);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= WAIT_COLON;
      have_hi          <= 1'b0;
      hi_nib           <= 4'h0;
      count            <= 8'h00;
      rec_type         <= 8'h00;
      idx              <= 8'h00;
      csum             <= 8'h00;
      rec_addr         <= 16'h0000;
      o_addr           <= '0;
      o_data           <= 8'h00;
      o_data_valid     <= 1'b0;
      o_idle           <= 1'b1;
      o_error_code     <= ERR_NONE;
      o_parse_complete <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      if (i_en) begin
        case (state)
          WAIT_COLON: begin
            if (is_colon) begin
              state   <= COUNT;
              csum    <= 8'h00;
              have_hi <= 1'b0;
              o_idle  <= 1'b0;
            end
          end
          DONE, ERROR: ;
          default: begin
            if (is_colon) begin
              state   <= COUNT;
              csum    <= 8'h00;
              have_hi <= 1'b0;
            end else if (!nib_ok) begin
              state        <= ERROR;
              o_error_code <= ERR_BAD_CHAR;
            end else if (!have_hi) begin
              hi_nib  <= nib;
              have_hi <= 1'b1;
            end else begin
              have_hi <= 1'b0;
              csum    <= csum_next;
              case (state)
                COUNT: begin
                  count <= byte_val;
                  state <= ADDR_HI;
                end
                ADDR_HI: begin
                  rec_addr[15:8] <= byte_val;
                  state          <= ADDR_LO;
                end
                ADDR_LO: begin
                  rec_addr[7:0] <= byte_val;
                  state         <= TYPE;
                end
                TYPE: begin
                  rec_type <= byte_val;
                  idx      <= 8'h00;
                  if (byte_val == REC_DATA) begin
                    state <= (count == 8'h00) ? CHECKSUM : DATA;
                  end else if (byte_val == REC_EOF && count == 8'h00) begin
                    state <= CHECKSUM;
                  end else if (byte_val == REC_EOF) begin
                    state        <= ERROR;
                    o_error_code <= ERR_EOF_COUNT;
                  end else begin
                    state        <= ERROR;
                    o_error_code <= ERR_BAD_TYPE;
                  end
                end
                DATA: begin
                  o_data       <= byte_val;
                  o_addr       <= ADDR_W'(rec_addr) + ADDR_W'(idx);
                  o_data_valid <= 1'b1;
                  idx          <= idx + 8'd1;
                  if (idx + 8'd1 == count) state <= CHECKSUM;
                end
                CHECKSUM: begin
                  if (csum_bad) begin
                    state        <= ERROR;
                    o_error_code <= ERR_CHECKSUM;
                  end else if (rec_type == REC_EOF) begin
                    state            <= DONE;
                    o_parse_complete <= 1'b1;
                    o_idle           <= 1'b1;
                  end else begin
                    state  <= WAIT_COLON;
                    o_idle <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_intel_hex_parser.sv
// Self-checking bench for intel_hex_parser: directed vector table, hand-written timing/reset
// sequences, and randomized records checked against a byte-list reference model.
module tb_intel_hex_parser;

  localparam int ADDR_W = 16;
`ifdef IHEX_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  localparam logic [2:0] CK_ERR  = CK_EN ? 3'd2 : 3'd0;
  localparam logic       CK_IDLE = !CK_EN;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_en;
  logic [7:0]        i_data;
  logic [ADDR_W-1:0] o_addr;
  logic [7:0]        o_data;
  logic              o_data_valid;
  logic              o_idle;
  logic [2:0]        o_error_code;
  logic              o_parse_complete;

  int checks = 0;
  int errors = 0;
  logic [23:0] act_q[$];
  logic [23:0] exp_q[$];
  logic        prev_valid = 1'b0;

  logic [2:0] m_err;
  logic       m_idle;
  logic       m_done;

  typedef struct {
    string           line;
    int              np;
    logic [2:0][15:0] addr;
    logic [2:0][7:0]  data;
    logic [2:0]      err;
    logic            idle;
    logic            done;
  } vec_t;
  vec_t vecs[$];

  always #5 i_clk = ~i_clk;

  intel_hex_parser #(.ADDR_W(ADDR_W)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_en             (i_en),
    .i_data           (i_data),
    .o_addr           (o_addr),
    .o_data           (o_data),
    .o_data_valid     (o_data_valid),
    .o_idle           (o_idle),
    .o_error_code     (o_error_code),
    .o_parse_complete (o_parse_complete)
  );

  // Collect every data pulse; two back-to-back valid cycles are impossible for a legal pulse.
  always @(negedge i_clk) begin
    if (o_data_valid) act_q.push_back({o_addr, o_data});
    if (o_data_valid && prev_valid) begin
      errors++;
      $display("FAIL pulse_width: o_data_valid high two cycles in a row at %0t", $time);
    end
    prev_valid <= o_data_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rst  = 1'b1;
    i_en   = 1'b0;
    i_data = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    act_q.delete();
  endtask

  task automatic send_char(input logic [7:0] c, input int gap);
    for (int g = 0; g < gap; g++) begin
      i_en   = 1'b0;
      i_data = 8'($urandom);
      @(posedge i_clk);
      #1;
    end
    i_en   = 1'b1;
    i_data = c;
    @(posedge i_clk);
    #1;
    i_en   = 1'b0;
    i_data = 8'($urandom);
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) send_char(s[i], $urandom_range(0, max_gap));
    repeat (2) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic compare_run(input string tag, input logic [2:0] err, input logic idle,
                             input logic done);
    int n;
    check({tag, " error_code"}, 32'(o_error_code), 32'(err));
    check({tag, " idle"}, 32'(o_idle), 32'(idle));
    check({tag, " parse_complete"}, 32'(o_parse_complete), 32'(done));
    check({tag, " pulse_count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s pulse%0d addr", tag, i), 32'(act_q[i][23:8]), 32'(exp_q[i][23:8]));
      check($sformatf("%s pulse%0d data", tag, i), 32'(act_q[i][7:0]), 32'(exp_q[i][7:0]));
    end
  endtask

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [7:0] hexv(input logic [7:0] c);
    if (c >= "a") return c - 8'd87;
    if (c >= "A") return c - 8'd55;
    return c - 8'd48;
  endfunction

  // Reference: gather the record's bytes into a list and judge it as each byte lands.
  task automatic model(input string s);
    int mode;  // 0 between records, 1 in a record, 2 finished, 3 failed
    logic [7:0] bytes[$];
    logic [7:0] hi, sum;
    bit have;
    int nb, cnt;
    exp_q.delete();
    m_err = 3'd0;
    mode  = 0;
    have  = 0;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      if (mode == 0) begin
        if (c == ":") begin mode = 1; bytes.delete(); have = 0; end
      end else if (mode == 1) begin
        if (c == ":") begin
          bytes.delete();
          have = 0;
        end else if (!is_hex(c)) begin
          mode = 3; m_err = 3'd1;
        end else if (!have) begin
          hi = hexv(c); have = 1;
        end else begin
          have = 0;
          bytes.push_back(8'(hi * 16 + hexv(c)));
          nb  = bytes.size();
          cnt = bytes[0];
          if (nb == 4) begin
            if (bytes[3] == 8'h01 && cnt != 0) begin mode = 3; m_err = 3'd4; end
            else if (bytes[3] > 8'h01) begin mode = 3; m_err = 3'd3; end
          end else if (nb > 4 && nb <= 4 + cnt) begin
            exp_q.push_back({16'(bytes[1] * 256 + bytes[2] + (nb - 5)), bytes[nb-1]});
          end
          if (mode == 1 && nb == 5 + cnt) begin
            sum = 8'h00;
            foreach (bytes[k]) sum = sum + bytes[k];
            if (CK_EN && sum != 8'h00) begin mode = 3; m_err = 3'd2; end
            else if (bytes[3] == 8'h01) mode = 2;
            else mode = 0;
          end
        end
      end
    end
    m_idle = (mode == 0) || (mode == 2);
    m_done = (mode == 2);
  endtask

  function automatic string gen_record();
    int cnt, sel;
    logic [15:0] a;
    logic [7:0] t, sum, b;
    logic [7:0] bl[$];
    string s;
    cnt = $urandom_range(0, 4);
    a   = 16'($urandom);
    sel = $urandom_range(0, 9);
    t   = (sel < 6) ? 8'h00 : (sel < 8) ? 8'h01 : (sel == 8) ? 8'h02 : 8'h04;
    if (t == 8'h01 && $urandom_range(0, 2) != 0) cnt = 0;
    bl.push_back(8'(cnt));
    bl.push_back(a[15:8]);
    bl.push_back(a[7:0]);
    bl.push_back(t);
    for (int i = 0; i < cnt; i++) bl.push_back(8'($urandom));
    sum = 8'h00;
    foreach (bl[k]) sum = sum + bl[k];
    b = 8'h00 - sum;
    if ($urandom_range(0, 3) == 0) b = b + 8'd1;
    bl.push_back(b);
    s = ":";
    foreach (bl[k]) s = {s, ($urandom_range(0, 1) != 0) ? $sformatf("%02x", bl[k])
                                                         : $sformatf("%02X", bl[k])};
    return s;
  endfunction

  task automatic add_vec(input string line, input int np, input logic [2:0][15:0] addr,
                         input logic [2:0][7:0] data, input logic [2:0] err,
                         input logic idle, input logic done);
    vec_t v;
    v.line = line; v.np = np; v.addr = addr; v.data = data;
    v.err = err; v.idle = idle; v.done = done;
    vecs.push_back(v);
  endtask

  initial begin
    string s, junk;
    int p;

    add_vec(":0300300002337A1E\r\n", 3, {16'h0032, 16'h0031, 16'h0030},
            {8'h7A, 8'h33, 8'h02}, 3'd0, 1'b1, 1'b0);
    add_vec(":00000001FF:", 0, '0, '0, 3'd0, 1'b1, 1'b1);
    add_vec(":00000001FF:0100000011EE", 0, '0, '0, 3'd0, 1'b1, 1'b1);
    add_vec(":0300300002337A1F", 3, {16'h0032, 16'h0031, 16'h0030},
            {8'h7A, 8'h33, 8'h02}, CK_ERR, CK_IDLE, 1'b0);
    add_vec(":02FFFF00AABB4B", 2, {16'h0000, 16'h0000, 16'hFFFF},
            {8'h00, 8'hBB, 8'hAA}, CK_ERR, CK_IDLE, 1'b0);
    add_vec(":02FFFF00AABB9B", 2, {16'h0000, 16'h0000, 16'hFFFF},
            {8'h00, 8'hBB, 8'hAA}, 3'd0, 1'b1, 1'b0);
    add_vec(":0G", 0, '0, '0, 3'd1, 1'b0, 1'b0);
    add_vec(":02000002AABB", 0, '0, '0, 3'd3, 1'b0, 1'b0);
    add_vec(":01000001AA55", 0, '0, '0, 3'd4, 1'b0, 1'b0);
    add_vec(" \r\n:01abcd00ee99", 1, {16'h0, 16'h0, 16'hABCD}, {8'h0, 8'h0, 8'hEE},
            3'd0, 1'b1, 1'b0);
    add_vec(":03:0100000011EE", 1, '0, {8'h0, 8'h0, 8'h11}, 3'd0, 1'b1, 1'b0);
    add_vec(":0000000000", 0, '0, '0, 3'd0, 1'b1, 1'b0);

    // Reset state.
    do_reset();
    check("reset idle", 32'(o_idle), 32'd1);
    check("reset error_code", 32'(o_error_code), 32'd0);
    check("reset parse_complete", 32'(o_parse_complete), 32'd0);
    check("reset data_valid", 32'(o_data_valid), 32'd0);
    check("reset addr", 32'(o_addr), 32'd0);
    check("reset data", 32'(o_data), 32'd0);

    // Directed vector table.
    foreach (vecs[v]) begin
      do_reset();
      send_str(vecs[v].line, 1);
      exp_q.delete();
      for (int i = 0; i < vecs[v].np; i++) exp_q.push_back({vecs[v].addr[i], vecs[v].data[i]});
      compare_run($sformatf("vec%0d", v), vecs[v].err, vecs[v].idle, vecs[v].done);
    end

    // A reset after an error clears the sticky code.
    do_reset();
    send_str(":0G", 0);
    check("err_before_reset", 32'(o_error_code), 32'd1);
    do_reset();
    check("err_after_reset code", 32'(o_error_code), 32'd0);
    check("err_after_reset idle", 32'(o_idle), 32'd1);

    // Pulse timing: valid exactly in the cycle after the second nibble strobe.
    do_reset();
    s = ":01000000";
    for (int i = 0; i < s.len(); i++) send_char(s[i], 0);
    send_char("A", 0);
    check("timing after_hi_nibble valid", 32'(o_data_valid), 32'd0);
    send_char("B", 0);
    check("timing pulse valid", 32'(o_data_valid), 32'd1);
    check("timing pulse data", 32'(o_data), 32'hAB);
    check("timing pulse addr", 32'(o_addr), 32'h0000);
    @(posedge i_clk);
    #1;
    check("timing pulse ends", 32'(o_data_valid), 32'd0);

    // Mid-record reset discards the partial record.
    do_reset();
    send_str(":0300300002", 0);
    do_reset();
    send_str(":00000001FF", 0);
    exp_q.delete();
    compare_run("midreset", 3'd0, 1'b1, 1'b1);

    // Characters presented with i_en low are ignored, even bad ones.
    do_reset();
    send_str(":01", 0);
    s = "G:0Zq:";
    for (int i = 0; i < s.len(); i++) begin
      i_en   = 1'b0;
      i_data = s[i];
      @(posedge i_clk);
      #1;
    end
    check("en_low idle", 32'(o_idle), 32'd0);
    check("en_low error_code", 32'(o_error_code), 32'd0);
    send_str("000000AA55", 0);
    exp_q.delete();
    exp_q.push_back({16'h0000, 8'hAA});
    compare_run("en_low", 3'd0, 1'b1, 1'b0);

    // Randomized record streams against the reference model.
    junk = "gZx/ @:";
    for (int t = 0; t < 40; t++) begin
      s = ($urandom_range(0, 1) != 0) ? "\r\n" : "";
      for (int r = 0; r < $urandom_range(1, 3); r++) s = {s, gen_record(), "\r\n"};
      if ($urandom_range(0, 7) == 0) begin
        p = $urandom_range(1, s.len() - 1);
        s = {s.substr(0, p - 1), string'(junk[$urandom_range(0, 6)]), s.substr(p, s.len() - 1)};
      end
      do_reset();
      send_str(s, 2);
      model(s);
      compare_run($sformatf("rand%0d", t), m_err, m_idle, m_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intel_hex_parser.md
INTEL_HEX_PARSER -- requirements
Module: intel_hex_parser

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the width of o_addr and of the record address field.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_en, input, 1 bit: one-cycle strobe marking i_data as a received character.
REQ-005 SHALL have port i_data, input, 8 bits: the received ASCII character.
REQ-006 SHALL have port o_addr, output, ADDR_W bits: target address of the current data byte.
REQ-007 SHALL have port o_data, output, 8 bits: decoded data byte.
REQ-008 SHALL have port o_data_valid, output, 1 bit: one-cycle pulse qualifying o_addr/o_data.
REQ-009 SHALL have port o_idle, output, 1 bit: high while waiting for a record start.
REQ-010 SHALL have port o_error_code, output, 3 bits: sticky error code.
REQ-011 SHALL have port o_parse_complete, output, 1 bit: high once a valid EOF record has been parsed.

Function
REQ-012 SHALL consume one character per cycle with i_en high and ignore i_data when i_en is low.
REQ-013 SHALL implement states WAIT_COLON, COUNT, ADDR_HI, ADDR_LO, TYPE, DATA, CHECKSUM, DONE and ERROR; each field except DATA is one byte of two ASCII hex nibbles, high nibble first.
REQ-014 In WAIT_COLON, ':' SHALL go to COUNT and clear the running checksum; every other character (CR, LF, space, etc.) SHALL be ignored.
REQ-015 Hex digits SHALL be '0'-'9', 'A'-'F' and 'a'-'f'; any other character inside a record SHALL go to ERROR with code 1, except ':', which restarts the record (go to COUNT) without error.
REQ-016 Type 00 SHALL go to DATA, or to CHECKSUM if the count is 0; type 01 with count 0 SHALL go to CHECKSUM; type 01 with a nonzero count SHALL set code 4; any other type SHALL set code 3 (both go to ERROR).
REQ-017 In DATA, each completed byte SHALL pulse o_data_valid for exactly one cycle, in the cycle after the strobe carrying the second nibble, with o_data set to the byte and o_addr set to record address + byte index, modulo 2^ADDR_W.
REQ-018 Data bytes SHALL be emitted before the checksum is verified, and a later checksum error SHALL NOT retract bytes already emitted.
REQ-019 The checksum SHALL be the 8-bit sum of the count, address, type, data and checksum bytes, and SHALL be valid when the sum is 0x00.
REQ-020 A valid checksum SHALL return a data record to WAIT_COLON and send an EOF record to DONE, setting o_parse_complete.
REQ-021 DONE SHALL ignore all input, keep o_idle high and hold o_parse_complete until reset.
REQ-022 ERROR SHALL hold o_error_code, keep o_idle low and ignore all input until reset.
REQ-023 o_idle SHALL be high only in WAIT_COLON and DONE.
REQ-024 Error codes SHALL be: 0 none, 1 bad character, 2 checksum mismatch, 3 unsupported type, 4 EOF record with a nonzero count.

Reset
REQ-025 i_rst SHALL force state WAIT_COLON, o_addr=0, o_data=0, o_data_valid=0, o_error_code=0, o_parse_complete=0 and o_idle=1; reset in mid-record SHALL discard the partial record.

Configuration
REQ-026 With IHEX_CHECKSUM_EN defined, a checksum mismatch SHALL go to ERROR with code 2.
REQ-027 Without IHEX_CHECKSUM_EN, the checksum byte SHALL still be parsed for hex validity, but the sum SHALL NOT be checked and code 2 SHALL never occur.

Structure
REQ-028 Package intel_hex_pkg SHALL hold the state enum, the error-code constants, the record-type constants (00, 01) and the ':' character constant.
REQ-029 Sub-module hex_nibble_decode SHALL be combinational, mapping an ASCII character to a 4-bit value plus a valid flag.

Verification
REQ-030 ":0300300002337A1E\r\n" SHALL give o_data_valid pulses (0x0030,0x02), (0x0031,0x33), (0x0032,0x7A), then o_idle=1 and o_error_code=0.
REQ-031 ":00000001FF" SHALL set o_parse_complete=1 and o_idle=1; a following ":" SHALL produce no activity.
REQ-032 ":0300300002337A1F" SHALL emit 3 bytes, then o_error_code=2 and o_idle=0 (with IHEX_CHECKSUM_EN); without the macro, o_error_code SHALL stay 0.
REQ-033 ":02FFFF00AABB4B" SHALL give pulses (0xFFFF,0xAA), then (0x0000,0xBB).
REQ-034 ":0G" SHALL set o_error_code=1; a later i_rst pulse SHALL restore o_error_code=0 and o_idle=1.
REQ-035 i_en held low while i_data carries characters SHALL cause no state change.
